// File: rtl/worley_field_pipeline.sv
// worley_field_pipeline: animated-seed distance noise, 3-stage pipe.
// Seeds bounce once per frame; one pixel per cycle, fixed latency 3.
module worley_field_pipeline #(
  parameter int NPTS  = 4,
  parameter int XW    = 10,
  parameter int XMAX  = 639,
  parameter int YMAX  = 479,
  parameter int T     = 4,
  parameter int R     = 3,
  parameter int SHIFT = 5,
  parameter int OUT_W = 18,
  localparam int CIW  = $clog2(NPTS)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             frame_tick,
  input  logic [1:0]       mode,
  input  logic             in_valid,
  input  logic [XW-1:0]    x,
  input  logic [XW-1:0]    y,
  output logic             out_valid,
  output logic [OUT_W-1:0] noise,
  output logic [CIW-1:0]   cell_id
);

  localparam int SQW = 2 * (XW + 1);
  localparam int DW  = SQW + 1;
  localparam int AW  = DW + CIW + 1;
  localparam logic [XW:0] LMASK = (XW+1)'((1 << T) - 1);
  localparam logic [OUT_W-1:0] OMAX = '1;

  typedef enum logic [1:0] {
    M_F1, M_F2, M_SUM, M_CELL
  } mode_e;

  typedef struct packed {
    logic                   v;
    mode_e                  md;
    logic [NPTS-1:0][XW:0]  ax;
    logic [NPTS-1:0][XW:0]  ay;
  } s1_t;

  typedef struct packed {
    logic                   v;
    mode_e                  md;
    logic [NPTS-1:0][DW-1:0] d;
  } s2_t;

  logic [NPTS-1:0][XW-1:0] px, py;
  logic [NPTS-1:0]         sx, sy;
  logic [NPTS-1:0][XW+1:0] nx, ny;
  logic [NPTS-1:0]         ox, oy;

  s1_t s1_d, s1_q;
  s2_t s2_d, s2_q;

  logic [DW-1:0]    m1, m2;
  logic [CIW-1:0]   ci;
  logic [AW-1:0]    acc;
  logic [OUT_W-1:0] nz;

  // sign bit neg=1 means the point moves toward 0 on that axis
  function automatic logic [XW+1:0] vstep(
    input logic [XW-1:0] p,
    input logic          neg,
    input int            i
  );
    logic [XW+1:0] m;
    m = (XW+2)'(1 + i % 2);
    return {2'b00, p} + (neg ? -m : m);
  endfunction

  function automatic logic off(
    input logic [XW+1:0] n,
    input int            mx
  );
    return n[XW+1] || (n > (XW+2)'(mx));
  endfunction

  function automatic logic [XW:0] absd(
    input logic [XW-1:0] a,
    input logic [XW-1:0] b
  );
    logic [XW:0] d;
    d = {1'b0, a} - {1'b0, b};
    return d[XW] ? -d : d;
  endfunction

  function automatic logic [SQW-1:0] asq(
    input logic [XW:0] a
  );
    logic [SQW-1:0] h, l;
    h = SQW'(a >> T);
    l = SQW'((a & LMASK) >> (T - R));
    return ((h * h) << (2 * T)) +
           ((h * l) << (2 * T - R + 1));
  endfunction

  function automatic logic [OUT_W-1:0] sat(
    input logic [DW-1:0] v
  );
    logic [DW-1:0] s;
    s = v >> SHIFT;
    return (s > DW'(OMAX)) ? OMAX : OUT_W'(s);
  endfunction

  always_comb begin
    nx = '0;
    ny = '0;
    ox = '0;
    oy = '0;
    for (int i = 0; i < NPTS; i++) begin
      nx[i] = vstep(px[i], sx[i], i);
      ny[i] = vstep(py[i], sy[i], i);
      ox[i] = off(nx[i], XMAX);
      oy[i] = off(ny[i], YMAX);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NPTS; i++) begin
        px[i] <= XW'((100 + 200 * i) % (XMAX + 1));
        py[i] <= XW'((100 + 120 * i) % (YMAX + 1));
        sx[i] <= (i % 2) == 1;
        sy[i] <= (i % 2) == 0;
      end
    end else if (frame_tick) begin
      for (int i = 0; i < NPTS; i++) begin
        if (ox[i]) sx[i] <= ~sx[i];
        else       px[i] <= nx[i][XW-1:0];
        if (oy[i]) sy[i] <= ~sy[i];
        else       py[i] <= ny[i][XW-1:0];
      end
    end
  end

  always_comb begin
    s1_d    = '0;
    s1_d.v  = in_valid;
    s1_d.md = mode_e'(mode);
    for (int i = 0; i < NPTS; i++) begin
      s1_d.ax[i] = absd(x, px[i]);
      s1_d.ay[i] = absd(y, py[i]);
    end
  end

  always_comb begin
    s2_d    = '0;
    s2_d.v  = s1_q.v;
    s2_d.md = s1_q.md;
    for (int i = 0; i < NPTS; i++)
      s2_d.d[i] = {1'b0, asq(s1_q.ax[i])} +
                  {1'b0, asq(s1_q.ay[i])};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q <= '0;
      s2_q <= '0;
    end else begin
      s1_q <= s1_d;
      s2_q <= s2_d;
    end
  end

  // strict < keeps the lowest index on ties
  always_comb begin
    m1 = s2_q.d[0];
    ci = '0;
    for (int i = 1; i < NPTS; i++)
      if (s2_q.d[i] < m1) begin
        m1 = s2_q.d[i];
        ci = CIW'(i);
      end
    m2 = '1;
    for (int i = 0; i < NPTS; i++)
      if (CIW'(i) != ci && s2_q.d[i] < m2)
        m2 = s2_q.d[i];
    acc = '0;
    for (int i = 0; i < NPTS; i++)
      if (i % 2 == 1) acc = acc - AW'(s2_q.d[i]);
      else            acc = acc + AW'(s2_q.d[i]);
    nz = '0;
    unique case (s2_q.md)
      M_F1:    nz = sat(m1);
      M_F2:    nz = sat(m2 - m1);
      M_SUM:   nz = ~acc[SHIFT +: OUT_W];
      default: nz = OUT_W'(ci) << (OUT_W - CIW);
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      noise     <= '0;
      cell_id   <= '0;
    end else begin
      out_valid <= s2_q.v;
      if (s2_q.v) begin
        noise   <= nz;
        cell_id <= ci;
      end
    end
  end

endmodule

// File: tb/tb_worley_field_pipeline.sv
// tb_worley_field_pipeline: scoreboard bench, exact (T=0) and
// approximate (T=4,R=3) instances driven in lockstep.
module tb_worley_field_pipeline;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        frame_tick = 1'b0;
  logic        in_valid = 1'b0;
  logic [1:0]  mode = '0;
  logic [9:0]  x = '0, y = '0;
  logic        ov0, ov1;
  logic [17:0] nz0, nz1;
  logic [1:0]  ci0, ci1;

  always #5 clk = ~clk;

  worley_field_pipeline #(.T(0), .R(0)) u_exact (
    .clk(clk), .rst_n(rst_n), .frame_tick(frame_tick),
    .mode(mode), .in_valid(in_valid), .x(x), .y(y),
    .out_valid(ov0), .noise(nz0), .cell_id(ci0)
  );

  worley_field_pipeline u_apx (
    .clk(clk), .rst_n(rst_n), .frame_tick(frame_tick),
    .mode(mode), .in_valid(in_valid), .x(x), .y(y),
    .out_valid(ov1), .noise(nz1), .cell_id(ci1)
  );

  typedef struct {
    int          cyc;
    logic [17:0] n0;
    logic [1:0]  c0;
    logic [17:0] n1;
    logic [1:0]  c1;
  } exp_t;

  exp_t sb[$];
  int   n_chk = 0, n_pass = 0, cyc = 0;
  int   mpx[4], mpy[4];
  bit   msx[4], msy[4];
  logic [17:0] last0, last1;

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
  endtask

  function automatic void model_reset();
    for (int i = 0; i < 4; i++) begin
      mpx[i] = (100 + 200 * i) % 640;
      mpy[i] = (100 + 120 * i) % 480;
      msx[i] = (i % 2) == 1;
      msy[i] = (i % 2) == 0;
    end
  endfunction

  function automatic void model_tick();
    for (int i = 0; i < 4; i++) begin
      int m, n;
      m = 1 + i % 2;
      n = mpx[i] + (msx[i] ? -m : m);
      if (n < 0 || n > 639) msx[i] = !msx[i];
      else mpx[i] = n;
      n = mpy[i] + (msy[i] ? -m : m);
      if (n < 0 || n > 479) msy[i] = !msy[i];
      else mpy[i] = n;
    end
  endfunction

  function automatic int asq(int a, int t, int r);
    int h, lr;
    h  = a >> t;
    lr = (a & ((1 << t) - 1)) >> (t - r);
    return ((h * h) << (2 * t)) + ((2 * h * lr) << (2 * t - r));
  endfunction

  function automatic logic [17:0] sat(int v);
    int s;
    s = v >> 5;
    return (s > 262143) ? 18'h3ffff : 18'(s);
  endfunction

  function automatic void model(input int px_, py_, md, t, r,
                                output logic [17:0] nz,
                                output logic [1:0] cid);
    int d[4];
    int m1, m2, acc, ax, ay;
    logic [31:0] sh;
    for (int i = 0; i < 4; i++) begin
      ax = px_ - mpx[i]; if (ax < 0) ax = -ax;
      ay = py_ - mpy[i]; if (ay < 0) ay = -ay;
      d[i] = asq(ax, t, r) + asq(ay, t, r);
    end
    m1 = d[0]; cid = 0;
    for (int i = 1; i < 4; i++)
      if (d[i] < m1) begin m1 = d[i]; cid = 2'(i); end
    m2 = 32'h7fffffff;
    for (int i = 0; i < 4; i++)
      if (i != int'(cid) && d[i] < m2) m2 = d[i];
    acc = d[0] - d[1] + d[2] - d[3];
    sh = acc >>> 5;
    case (md)
      0: nz = sat(m1);
      1: nz = sat(m2 - m1);
      2: nz = ~sh[17:0];
      default: nz = 18'(cid) << 16;
    endcase
  endfunction

  task automatic step(bit tk, bit v, int px_, int py_, int md);
    exp_t e;
    @(negedge clk);
    frame_tick = tk; in_valid = v;
    x = 10'(px_); y = 10'(py_); mode = 2'(md);
    if (v) begin
      model(px_, py_, md, 0, 0, e.n0, e.c0);
      model(px_, py_, md, 4, 3, e.n1, e.c1);
      e.cyc = cyc + 3;
      sb.push_back(e);
    end
    if (tk) model_tick();
  endtask

  // exact-instance result given as a hand-derived constant
  task automatic step_k(int px_, int py_, int md,
                        logic [17:0] nz, logic [1:0] c);
    exp_t e;
    @(negedge clk);
    frame_tick = 1'b0; in_valid = 1'b1;
    x = 10'(px_); y = 10'(py_); mode = 2'(md);
    e.n0 = nz; e.c0 = c;
    model(px_, py_, md, 4, 3, e.n1, e.c1);
    e.cyc = cyc + 3;
    sb.push_back(e);
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    exp_t e;
    #1;
    if (!rst_n) begin
      last0 = '0; last1 = '0;
    end else if (ov0 || ov1) begin
      check("ov_pair", 32'(ov1), 32'(ov0));
      if (sb.size() == 0) check("unexpected_out", 1, 0);
      else begin
        e = sb.pop_front();
        check("latency", cyc, e.cyc);
        check("noise_exact", nz0, e.n0);
        check("cell_exact", ci0, e.c0);
        check("noise_apx", nz1, e.n1);
        check("cell_apx", ci1, e.c1);
      end
      last0 = nz0; last1 = nz1;
    end else begin
      check("hold_exact", nz0, last0);
      check("hold_apx", nz1, last1);
    end
  end

  initial begin
    model_reset();
    repeat (2) @(negedge clk);
    check("rst_ov", 32'(ov0), 0);
    check("rst_noise", nz0, 0);
    check("rst_cell", ci0, 0);
    check("rst_ov_apx", 32'(ov1), 0);
    rst_n = 1'b1;

    step_k(100, 100, 0, 18'd0, 2'd0);
    step_k(110, 100, 0, 18'd3, 2'd0);
    step_k(200, 160, 0, 18'd425, 2'd0);
    step_k(200, 160, 1, 18'd0, 2'd0);
    step_k(300, 220, 3, 18'h10000, 2'd1);
    step(0, 1, 320, 240, 2);
    step(0, 1, 50, 400, 3);
    step(0, 1, 639, 479, 2);
    step(0, 1, 0, 0, 1);
    step(0, 0, 0, 0, 0);

    step(1, 1, 100, 100, 0);
    step_k(100, 100, 0, 18'd0, 2'd0);
    step(0, 0, 0, 0, 0);

    repeat (300)
      step($urandom_range(0, 15) == 0, $urandom_range(0, 3) != 0,
           $urandom_range(0, 1023), $urandom_range(0, 1023),
           $urandom_range(0, 3));

    step(0, 1, 10, 20, 0);
    step(0, 1, 30, 40, 1);
    step(0, 1, 50, 60, 2);
    #2;
    rst_n = 1'b0;
    in_valid = 1'b0;
    #1;
    check("midrst_ov", 32'(ov0), 0);
    check("midrst_noise", nz0, 0);
    check("midrst_cell", ci0, 0);
    check("midrst_ov_apx", 32'(ov1), 0);
    sb.delete();
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    step_k(100, 100, 0, 18'd0, 2'd0);
    step_k(300, 220, 3, 18'h10000, 2'd1);
    step(0, 0, 0, 0, 0);

    for (int k = 1; k <= 150; k++)
      step(1, $urandom_range(0, 1), $urandom_range(0, 700),
           $urandom_range(0, 500), $urandom_range(0, 3));
    step_k(0, 438, 3, 18'h10000, 2'd1);
    step(1, 0, 0, 0, 0);
    step_k(0, 436, 3, 18'h10000, 2'd1);
    step(1, 0, 0, 0, 0);
    step_k(2, 434, 3, 18'h10000, 2'd1);
    step(0, 0, 0, 0, 0);

    for (int i = 0; i < 10 && sb.size() != 0; i++) @(negedge clk);
    check("drain", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
